pool_frame_driver: RTL and testbench

- Initiator side of the pool_module level handshake (in_vld / conv_lin -> out_vld / pool_lin).
- Collects a byte stream of conv results into a 6x6x3 frame and presents it to pool_module as conv_lin with in_vld held high.
- Waits for the out_vld rising edge, captures pool_lin, drops in_vld, then streams the 3x3x3 result bytes downstream over valid/ready.
- Sits between the conv engine output stream and the pool_module instance.

---
 rtl/pool_frame_driver.sv | 162 ++++++++++++++++
 tb/tb_pool_frame_driver.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_frame_driver.sv
// Initiator for the pool_module level handshake: gathers a conv frame from a byte
// stream, holds in_vld until out_vld rises, then streams the pooled bytes downstream.
module pool_frame_driver #(
  parameter int IN_DIM  = 6,
  parameter int OUT_DIM = 3,
  parameter int CH      = 3,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DW-1:0]                     s_data,
  input  logic                              s_vld,
  output logic                              s_rdy,
  output logic [IN_DIM*IN_DIM*CH*DW-1:0]    conv_lin,
  output logic                              in_vld,
  input  logic [OUT_DIM*OUT_DIM*CH*DW-1:0]  pool_lin,
  input  logic                              out_vld,
  output logic [DW-1:0]                     m_data,
  output logic                              m_vld,
  input  logic                              m_rdy,
  output logic                              err,
  output logic [15:0]                       frame_cnt
);

  localparam int NIN  = IN_DIM * IN_DIM * CH;
  localparam int NOUT = OUT_DIM * OUT_DIM * CH;
  localparam int IW   = $clog2(NIN);
  localparam int OW   = $clog2(NOUT);
  localparam int TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {LOAD, REQ, DRAIN} state_e;

  state_e              state_q,     state_d;
  logic [NIN*DW-1:0]   conv_lin_q,  conv_lin_d;
  logic [NOUT*DW-1:0]  res_q,       res_d;
  logic                in_vld_q,    in_vld_d;
  logic                s_rdy_q,     s_rdy_d;
  logic [DW-1:0]       m_data_q,    m_data_d;
  logic                m_vld_q,     m_vld_d;
  logic                err_q,       err_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [IW-1:0]       in_idx_q,    in_idx_d;
  logic [OW-1:0]       out_idx_q,   out_idx_d;
  logic [TW-1:0]       tmo_cnt_q,   tmo_cnt_d;
  logic [1:0]          gap_cnt_q,   gap_cnt_d;
  logic                out_vld_q;
  logic                rise;

  // Only a fresh low-to-high transition counts; a level left over from the last frame does not.
  assign rise = out_vld & ~out_vld_q;

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave a latch behind.
    state_d     = state_q;
    conv_lin_d  = conv_lin_q;
    res_d       = res_q;
    in_vld_d    = in_vld_q;
    m_data_d    = m_data_q;
    m_vld_d     = m_vld_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    in_idx_d    = in_idx_q;
    out_idx_d   = out_idx_q;
    tmo_cnt_d   = tmo_cnt_q;
    gap_cnt_d   = in_vld_q ? 2'd0 : (gap_cnt_q == 2'd3) ? 2'd3 : gap_cnt_q + 2'd1;

    unique case (state_q)
      LOAD: begin
        if (s_vld && s_rdy_q) begin
          conv_lin_d[int'(in_idx_q)*DW +: DW] = s_data;
          if (in_idx_q == IW'(NIN - 1)) begin
            in_idx_d  = '0;
            in_vld_d  = 1'b1;
            tmo_cnt_d = '0;
            state_d   = REQ;
          end else begin
            in_idx_d = in_idx_q + 1'b1;
          end
        end
      end
      REQ: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // A capture on the final timeout cycle still wins over the abort.
        if (rise) begin
          res_d     = pool_lin;
          m_data_d  = pool_lin[DW-1:0];
          m_vld_d   = 1'b1;
          in_vld_d  = 1'b0;
          out_idx_d = '0;
          state_d   = DRAIN;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          in_vld_d = 1'b0;
          state_d  = LOAD;
        end
      end
      DRAIN: begin
        if (m_vld_q && m_rdy) begin
          if (out_idx_q == OW'(NOUT - 1)) begin
            m_vld_d     = 1'b0;
            out_idx_d   = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = LOAD;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
            m_data_d  = res_q[int'(out_idx_d)*DW +: DW];
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Ready only opens once in_vld has been low long enough for pool_module to re-arm.
    s_rdy_d = (state_d == LOAD) && (gap_cnt_d >= 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the frame and result registers drive outputs, so they are cleared on reset like any other flop.
      state_q     <= LOAD;
      conv_lin_q  <= '0;
      res_q       <= '0;
      in_vld_q    <= 1'b0;
      s_rdy_q     <= 1'b0;
      m_data_q    <= '0;
      m_vld_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      out_vld_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q     <= state_d;
      conv_lin_q  <= conv_lin_d;
      res_q       <= res_d;
      in_vld_q    <= in_vld_d;
      s_rdy_q     <= s_rdy_d;
      m_data_q    <= m_data_d;
      m_vld_q     <= m_vld_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      in_idx_q    <= in_idx_d;
      out_idx_q   <= out_idx_d;
      tmo_cnt_q   <= tmo_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      out_vld_q   <= out_vld;
    end
  end

  assign s_rdy     = s_rdy_q;
  assign conv_lin  = conv_lin_q;
  assign in_vld    = in_vld_q;
  assign m_data    = m_data_q;
  assign m_vld     = m_vld_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pool_frame_driver.sv
// Scoreboard bench for pool_frame_driver: a pool_module stub answers in_vld, expected
// output bytes are queued as each frame is sent and popped as m_data is accepted.
module tb_pool_frame_driver;

  localparam int NIN  = 108;
  localparam int NOUT = 27;
  localparam int DW   = 8;
  localparam int TMO  = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [DW-1:0]       s_data;
  logic                s_vld;
  logic                s_rdy;
  logic [NIN*DW-1:0]   conv_lin;
  logic                in_vld;
  logic [NOUT*DW-1:0]  pool_lin;
  logic                out_vld;
  logic [DW-1:0]       m_data;
  logic                m_vld;
  logic                m_rdy;
  logic                err;
  logic [15:0]         frame_cnt;

  logic                stub_en;
  logic                stub_golden;
  int                  stub_lat;
  logic                stub_out_vld;
  logic [NOUT*DW-1:0]  stub_pool;
  logic                man_out_vld;
  logic [NOUT*DW-1:0]  man_pool;

  logic [DW-1:0]       frame_data [NIN];
  logic [DW-1:0]       exp_q [$];
  int                  n_pass = 0;
  int                  n_total = 0;

  logic                gap_mon_en = 1'b0;
  logic                in_vld_prev = 1'b0;
  int                  low_run = 1000;
  int                  min_gap = 1000;

  assign out_vld  = stub_en ? stub_out_vld : man_out_vld;
  assign pool_lin = stub_en ? stub_pool : man_pool;

  pool_frame_driver #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
    .conv_lin(conv_lin), .in_vld(in_vld),
    .pool_lin(pool_lin), .out_vld(out_vld),
    .m_data(m_data), .m_vld(m_vld), .m_rdy(m_rdy),
    .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // pool_module stub: answers stub_lat cycles after in_vld, drops out_vld once in_vld falls.
  initial begin
    stub_out_vld = 1'b0;
    stub_pool    = '0;
    forever begin
      @(negedge clk);
      if (!in_vld) stub_out_vld = 1'b0;
      else if (stub_en && !stub_out_vld) begin
        repeat (stub_lat) @(negedge clk);
        for (int j = 0; j < NOUT; j++)
          stub_pool[j*DW +: DW] = stub_golden ? conv_lin[(4*j+1)*DW +: DW] + 8'd7 : 8'(3*j);
        stub_out_vld = 1'b1;
      end
    end
  end

  // Shortest in_vld low run seen before a rise while monitoring is enabled.
  always @(negedge clk) begin
    in_vld_prev <= in_vld;
    if (!gap_mon_en) begin
      min_gap <= 1000;
      low_run <= 1000;
    end else if (in_vld) begin
      if (!in_vld_prev && low_run < min_gap) min_gap <= low_run;
      low_run <= 0;
    end else if (low_run < 1000) begin
      low_run <= low_run + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic fill_random();
    for (int i = 0; i < NIN; i++) frame_data[i] = 8'($urandom);
  endtask

  // Streams frame_data, pushing the bytes the DUT must later emit (kind 0 = none expected).
  task automatic send_frame(input bit bubbles, input int exp_kind);
    int idx = 0;
    int budget = 0;
    bit early_vld = 1'b0;
    int bad = -1;
    for (int j = 0; j < NOUT; j++) begin
      case (exp_kind)
        1: exp_q.push_back(8'(3*j));
        2: exp_q.push_back(frame_data[4*j+1] + 8'd7);
        3: exp_q.push_back(8'(100+j));
        default: ;
      endcase
    end
    while (idx < NIN && budget < 4000) begin
      @(posedge clk); #1;
      s_vld  = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = frame_data[idx];
      @(negedge clk);
      if (in_vld) early_vld = 1'b1;
      if (s_vld && s_rdy) idx++;
      budget++;
    end
    @(posedge clk); #1;
    s_vld = 1'b0;
    n_total++;
    if (idx != NIN) $display("FAIL send_accepts: got %0d want %0d", idx, NIN);
    else n_pass++;
    n_total++;
    if (early_vld) $display("FAIL in_vld_early: got 1 before last byte want 0");
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (in_vld !== 1'b1) $display("FAIL in_vld_rise: got %b want 1", in_vld);
    else n_pass++;
    for (int i = NIN - 1; i >= 0; i--)
      if (conv_lin[i*DW +: DW] !== frame_data[i]) bad = i;
    n_total++;
    if (bad >= 0)
      $display("FAIL conv_lin[%0d]: got %h want %h", bad, conv_lin[bad*DW +: DW], frame_data[bad]);
    else n_pass++;
  endtask

  // Accepts NOUT bytes (m_rdy 1,0,0 when bp) and compares each against the scoreboard.
  task automatic drain_frame(input bit bp, input logic [15:0] fc_before);
    int got = 0;
    int k = 0;
    logic [DW-1:0] want;
    while (got < NOUT && k < 2000) begin
      @(posedge clk); #1;
      m_rdy = bp ? (k % 3 == 0) : 1'b1;
      @(negedge clk);
      if (m_vld) begin
        want = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
        n_total++;
        if (m_data !== want) $display("FAIL m_data[%0d]: got %h want %h", got, m_data, want);
        else n_pass++;
        if (m_rdy) begin
          n_total++;
          if (frame_cnt !== fc_before)
            $display("FAIL frame_cnt_early[%0d]: got %0d want %0d", got, frame_cnt, fc_before);
          else n_pass++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          got++;
        end
      end
      k++;
    end
    @(posedge clk); #1;
    m_rdy = 1'b0;
    @(negedge clk);
    n_total++;
    if (got != NOUT) $display("FAIL drain_count: got %0d want %0d", got, NOUT);
    else n_pass++;
    n_total++;
    if (m_vld !== 1'b0) $display("FAIL m_vld_end: got %b want 0", m_vld);
    else n_pass++;
    n_total++;
    if (frame_cnt !== fc_before + 16'd1)
      $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, fc_before + 16'd1);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_vld = 1'b0; s_data = '0; m_rdy = 1'b0;
    stub_en = 1'b1; stub_golden = 1'b0; stub_lat = 5;
    man_out_vld = 1'b0; man_pool = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (s_rdy !== 1'b0 || in_vld !== 1'b0 || m_vld !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_ctrl: got s_rdy=%b in_vld=%b m_vld=%b err=%b want 0000", s_rdy, in_vld, m_vld, err);
    else n_pass++;
    n_total++;
    if (frame_cnt !== 16'd0 || m_data !== 8'd0 || conv_lin !== '0)
      $display("FAIL reset_data: got frame_cnt=%0d m_data=%h want 0 0 and conv_lin 0", frame_cnt, m_data);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (s_rdy !== 1'b0) $display("FAIL s_rdy_gap1: got %b want 0", s_rdy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (s_rdy !== 1'b1) $display("FAIL s_rdy_gap2: got %b want 1", s_rdy);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < NIN; i++) frame_data[i] = 8'(i);
    stub_en = 1'b1; stub_golden = 1'b0; stub_lat = 5;
    send_frame(1'b0, 1);
    drain_frame(1'b0, 16'd0);
    n_total++;
    if (err !== 1'b0) $display("FAIL single_err: got %b want 0", err);
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    fill_random();
    send_frame(1'b0, 1);
    drain_frame(1'b1, 16'd1);
  endtask

  task automatic test_bubbles();
    fill_random();
    stub_golden = 1'b1;
    send_frame(1'b1, 2);
    drain_frame(1'b0, 16'd2);
  endtask

  task automatic test_stale_out_vld();
    bit early = 1'b0;
    fill_random();
    stub_en = 1'b0;
    man_pool = {NOUT{8'hEE}};
    man_out_vld = 1'b1;
    send_frame(1'b0, 3);
    repeat (4) begin
      @(negedge clk);
      if (m_vld !== 1'b0 || in_vld !== 1'b1) early = 1'b1;
    end
    n_total++;
    if (early) $display("FAIL stale_capture: got capture on stale out_vld want wait for new rise");
    else n_pass++;
    @(posedge clk); #1;
    man_out_vld = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < NOUT; j++) man_pool[j*DW +: DW] = 8'(100+j);
    man_out_vld = 1'b1;
    drain_frame(1'b0, 16'd3);
    man_out_vld = 1'b0;
  endtask

  task automatic test_timeout();
    int hi = 0;
    int lo = 0;
    fill_random();
    stub_en = 1'b0;
    man_out_vld = 1'b0;
    send_frame(1'b0, 0);
    while (in_vld && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    n_total++;
    if (hi != TMO) $display("FAIL timeout_len: got %0d want %0d", hi, TMO);
    else n_pass++;
    n_total++;
    if (err !== 1'b1) $display("FAIL timeout_err: got %b want 1", err);
    else n_pass++;
    while (!s_rdy && lo < 20) begin
      lo++;
      @(negedge clk);
    end
    n_total++;
    if (lo != 2) $display("FAIL timeout_gap: got %0d want 2", lo);
    else n_pass++;
    fill_random();
    stub_en = 1'b1; stub_golden = 1'b1;
    send_frame(1'b0, 2);
    drain_frame(1'b0, 16'd4);
    n_total++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    fill_random();
    stub_en = 1'b0;
    man_out_vld = 1'b0;
    send_frame(1'b0, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (in_vld !== 1'b0 || s_rdy !== 1'b0)
      $display("FAIL mid_reset: got in_vld=%b s_rdy=%b want 0 0", in_vld, s_rdy);
    else n_pass++;
    n_total++;
    if (err !== 1'b0 || frame_cnt !== 16'd0)
      $display("FAIL mid_reset_state: got err=%b frame_cnt=%0d want 0 0", err, frame_cnt);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    gap_mon_en = 1'b1;
    stub_en = 1'b1; stub_golden = 1'b1;
    for (int f = 0; f < 100; f++) begin
      stub_lat = $urandom_range(1, 6);
      fill_random();
      send_frame(1'b0, 2);
      drain_frame(1'b0, 16'(f));
    end
    n_total++;
    if (frame_cnt !== 16'd100) $display("FAIL b2b_frame_cnt: got %0d want 100", frame_cnt);
    else n_pass++;
    n_total++;
    if (min_gap < 2) $display("FAIL in_vld_gap: got %0d want >=2", min_gap);
    else n_pass++;
    gap_mon_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_pressure();
    test_bubbles();
    test_stale_out_vld();
    test_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
